// File: rtl/time_of_day_counter.sv
// time_of_day_counter
// Time-of-day core: counts ms/sec/min/hour from a 1 ms tick, accepts a
// range-checked set-time request over valid/ready, and latches an alarm
// when a counting rollover lands on the programmed HH:MM:00.
module time_of_day_counter #(
    parameter int MS_PER_SEC = 1000,
    parameter int HOURS      = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ms_tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic       alarm_flag,
    output logic [9:0] ms,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       sec_tick
);

    localparam logic [9:0] MS_MAX   = 10'(MS_PER_SEC - 1);
    localparam logic [4:0] HOUR_MAX = 5'(HOURS - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] ms_q, ms_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [4:0] cap_hour_q, cap_hour_d;
    logic [5:0] cap_min_q, cap_min_d;
    logic [5:0] cap_sec_q, cap_sec_d;
    logic       set_ready_q, set_ready_d;
    logic       set_err_q, set_err_d;
    logic       alarm_flag_q, alarm_flag_d;
    logic       sec_tick_q, sec_tick_d;

    logic       accept_s;
    logic       in_range_s;
    logic       fire_s;

    // Next-state logic: handshake, load, counting with carries, alarm latch.
    always_comb begin
        state_d      = state_q;
        ms_d         = ms_q;
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        cap_hour_d   = cap_hour_q;
        cap_min_d    = cap_min_q;
        cap_sec_d    = cap_sec_q;
        set_ready_d  = set_ready_q;
        set_err_d    = 1'b0;
        sec_tick_d   = 1'b0;
        fire_s       = 1'b0;

        accept_s   = (state_q == ST_RUN) && set_valid && set_ready_q;
        in_range_s = (int'(set_hour) < HOURS) && (set_min <= 6'd59) && (set_sec <= 6'd59);

        case (state_q)
            ST_RUN: begin
                if (accept_s) begin
                    // A tick coinciding with a transfer is dropped.
                    if (in_range_s) begin
                        cap_hour_d  = set_hour;
                        cap_min_d   = set_min;
                        cap_sec_d   = set_sec;
                        state_d     = ST_LOAD;
                        set_ready_d = 1'b0;
                    end else begin
                        set_err_d = 1'b1;
                    end
                end else if (ms_tick) begin
                    if (ms_q != MS_MAX) begin
                        ms_d = ms_q + 10'd1;
                    end else begin
                        ms_d       = 10'd0;
                        sec_tick_d = 1'b1;
                        if (sec_q != 6'd59) begin
                            sec_d = sec_q + 6'd1;
                        end else begin
                            sec_d = 6'd0;
                            if (min_q != 6'd59) begin
                                min_d = min_q + 6'd1;
                            end else begin
                                min_d = 6'd0;
                                if (hour_q != HOUR_MAX) begin
                                    hour_d = hour_q + 5'd1;
                                end else begin
                                    hour_d = 5'd0;
                                end
                            end
                            // Only a counted rollover into :00 can fire.
                            fire_s = alarm_en && (min_d == alarm_min) && (hour_d == alarm_hour);
                        end
                    end
                end else begin
                    ms_d = ms_q;
                end
            end
            ST_LOAD: begin
                hour_d      = cap_hour_q;
                min_d       = cap_min_q;
                sec_d       = cap_sec_q;
                ms_d        = 10'd0;
                state_d     = ST_RUN;
                set_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                set_ready_d = 1'b1;
            end
        endcase

        // Disable clears and suppresses; a fire beats a same-cycle ack.
        if (!alarm_en) begin
            alarm_flag_d = 1'b0;
        end else if (fire_s) begin
            alarm_flag_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_flag_d = 1'b0;
        end else begin
            alarm_flag_d = alarm_flag_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            ms_q         <= 10'd0;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hour_q       <= 5'd0;
            cap_hour_q   <= 5'd0;
            cap_min_q    <= 6'd0;
            cap_sec_q    <= 6'd0;
            set_ready_q  <= 1'b1;
            set_err_q    <= 1'b0;
            alarm_flag_q <= 1'b0;
            sec_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_q         <= ms_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            cap_hour_q   <= cap_hour_d;
            cap_min_q    <= cap_min_d;
            cap_sec_q    <= cap_sec_d;
            set_ready_q  <= set_ready_d;
            set_err_q    <= set_err_d;
            alarm_flag_q <= alarm_flag_d;
            sec_tick_q   <= sec_tick_d;
        end
    end

    assign set_ready  = set_ready_q;
    assign set_err    = set_err_q;
    assign alarm_flag = alarm_flag_q;
    assign ms         = ms_q;
    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
    assign sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter with MS_PER_SEC=4.
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ms_tick = 1'b0;
    logic       set_valid = 1'b0;
    logic       set_ready;
    logic [4:0] set_hour = 5'd0;
    logic [5:0] set_min = 6'd0;
    logic [5:0] set_sec = 6'd0;
    logic       set_err;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = 5'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       alarm_ack = 1'b0;
    logic       alarm_flag;
    logic [9:0] ms;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       sec_tick;

    int pass_cnt = 0;
    int total_cnt = 0;

    time_of_day_counter #(.MS_PER_SEC(4), .HOURS(24)) dut (
        .clk(clk), .reset(reset), .ms_tick(ms_tick),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_err(set_err), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_ack(alarm_ack), .alarm_flag(alarm_flag),
        .ms(ms), .sec(sec), .min(min), .hour(hour), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one-cycle ticks.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            step();
        end
        ms_tick = 1'b0;
    endtask

    // Issue an in-range set request and wait until it is visible.
    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_hour = h; set_min = m; set_sec = s; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        total_cnt++;
        if ({hour, min, sec, ms} !== {5'd0, 6'd0, 6'd0, 10'd0})
            $display("FAIL reset_time got %0d:%0d:%0d.%0d exp 0:0:0.0", hour, min, sec, ms);
        else pass_cnt++;
        total_cnt++;
        if ({set_ready, set_err, alarm_flag, sec_tick} !== 4'b1000)
            $display("FAIL reset_flags got %b exp 1000", {set_ready, set_err, alarm_flag, sec_tick});
        else pass_cnt++;
    endtask

    task automatic test_rollover();
        logic [9:0] exp_ms;
        for (int i = 0; i < 4; i++) begin
            ms_tick = 1'b1;
            step();
            exp_ms = 10'((i + 1) % 4);
            total_cnt++;
            if (ms !== exp_ms) $display("FAIL rollover_ms got %0d exp %0d", ms, exp_ms);
            else pass_cnt++;
        end
        ms_tick = 1'b0;
        total_cnt++;
        if ({sec, sec_tick} !== {6'd1, 1'b1})
            $display("FAIL rollover_sec got sec=%0d tick=%b exp sec=1 tick=1", sec, sec_tick);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({sec, sec_tick, ms} !== {6'd1, 1'b0, 10'd0})
            $display("FAIL sec_tick_once got sec=%0d tick=%b ms=%0d exp 1 0 0", sec, sec_tick, ms);
        else pass_cnt++;
    endtask

    task automatic test_day_wrap();
        do_load(5'd23, 6'd59, 6'd59);
        total_cnt++;
        if ({hour, min, sec, ms} !== {5'd23, 6'd59, 6'd59, 10'd0})
            $display("FAIL wrap_load got %0d:%0d:%0d.%0d exp 23:59:59.0", hour, min, sec, ms);
        else pass_cnt++;
        ticks(4);
        total_cnt++;
        if ({hour, min, sec, ms, sec_tick} !== {5'd0, 6'd0, 6'd0, 10'd0, 1'b1})
            $display("FAIL day_wrap got %0d:%0d:%0d.%0d tick=%b exp 0:0:0.0 tick=1", hour, min, sec, ms, sec_tick);
        else pass_cnt++;
    endtask

    task automatic test_set();
        ticks(1);
        set_hour = 5'd12; set_min = 6'd34; set_sec = 6'd56;
        set_valid = 1'b1; ms_tick = 1'b1;
        step();
        set_valid = 1'b0; ms_tick = 1'b0;
        total_cnt++;
        if (set_ready !== 1'b0) $display("FAIL set_ready_low got %b exp 0", set_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({hour, min, sec, ms, set_ready} !== {5'd12, 6'd34, 6'd56, 10'd0, 1'b1})
            $display("FAIL set_load got %0d:%0d:%0d.%0d rdy=%b exp 12:34:56.0 rdy=1", hour, min, sec, ms, set_ready);
        else pass_cnt++;
        // Out-of-range hour is rejected.
        set_hour = 5'd24; set_min = 6'd0; set_sec = 6'd0; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        total_cnt++;
        if ({set_err, set_ready} !== 2'b11)
            $display("FAIL set_reject got err=%b rdy=%b exp err=1 rdy=1", set_err, set_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({hour, min, sec, set_err} !== {5'd12, 6'd34, 6'd56, 1'b0})
            $display("FAIL reject_unchanged got %0d:%0d:%0d err=%b exp 12:34:56 err=0", hour, min, sec, set_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_hour = 5'd1; set_min = 6'd2; set_sec = 6'd3; set_valid = 1'b1;
        step();
        step();
        total_cnt++;
        if ({hour, min, sec, set_ready} !== {5'd1, 6'd2, 6'd3, 1'b1})
            $display("FAIL b2b_first got %0d:%0d:%0d rdy=%b exp 1:2:3 rdy=1", hour, min, sec, set_ready);
        else pass_cnt++;
        step();
        set_valid = 1'b0;
        total_cnt++;
        if (set_ready !== 1'b0) $display("FAIL b2b_second got rdy=%b exp 0", set_ready);
        else pass_cnt++;
        step();
    endtask

    task automatic test_alarm();
        alarm_en = 1'b1;
        do_load(5'd7, 6'd29, 6'd59);
        ticks(3);
        total_cnt++;
        if (alarm_flag !== 1'b0) $display("FAIL alarm_early got %b exp 0", alarm_flag);
        else pass_cnt++;
        ticks(1);
        total_cnt++;
        if ({hour, min, sec, alarm_flag} !== {5'd7, 6'd30, 6'd0, 1'b1})
            $display("FAIL alarm_fire got %0d:%0d:%0d flag=%b exp 7:30:0 flag=1", hour, min, sec, alarm_flag);
        else pass_cnt++;
        step();
        total_cnt++;
        if (alarm_flag !== 1'b1) $display("FAIL alarm_hold got %b exp 1", alarm_flag);
        else pass_cnt++;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        total_cnt++;
        if (alarm_flag !== 1'b0) $display("FAIL alarm_ack got %b exp 0", alarm_flag);
        else pass_cnt++;
        // Ack on the fire cycle loses to the fire.
        do_load(5'd7, 6'd29, 6'd59);
        ticks(3);
        alarm_ack = 1'b1; ms_tick = 1'b1;
        step();
        alarm_ack = 1'b0; ms_tick = 1'b0;
        step();
        total_cnt++;
        if (alarm_flag !== 1'b1) $display("FAIL fire_beats_ack got %b exp 1", alarm_flag);
        else pass_cnt++;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
    endtask

    task automatic test_alarm_guards();
        do_load(5'd7, 6'd30, 6'd0);
        step();
        total_cnt++;
        if (alarm_flag !== 1'b0) $display("FAIL load_no_fire got %b exp 0", alarm_flag);
        else pass_cnt++;
        alarm_en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        ticks(4);
        total_cnt++;
        if ({min, sec, alarm_flag} !== {6'd30, 6'd0, 1'b0})
            $display("FAIL disabled_no_fire got min=%0d sec=%0d flag=%b exp 30 0 0", min, sec, alarm_flag);
        else pass_cnt++;
        alarm_en = 1'b1;
        do_load(5'd7, 6'd29, 6'd59);
        ticks(4);
        total_cnt++;
        if (alarm_flag !== 1'b1) $display("FAIL refire got %b exp 1", alarm_flag);
        else pass_cnt++;
        alarm_en = 1'b0;
        step();
        total_cnt++;
        if (alarm_flag !== 1'b0) $display("FAIL en_clear got %b exp 0", alarm_flag);
        else pass_cnt++;
        alarm_en = 1'b1;
    endtask

    task automatic test_reset_in_load();
        set_hour = 5'd5; set_min = 6'd6; set_sec = 6'd7; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++;
        if ({hour, min, sec, ms, set_ready, set_err} !== {5'd0, 6'd0, 6'd0, 10'd0, 1'b1, 1'b0})
            $display("FAIL reset_in_load got %0d:%0d:%0d.%0d rdy=%b err=%b exp 0:0:0.0 rdy=1 err=0",
                     hour, min, sec, ms, set_ready, set_err);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({hour, min, sec, set_ready} !== {5'd0, 6'd0, 6'd0, 1'b1})
            $display("FAIL load_discarded got %0d:%0d:%0d rdy=%b exp 0:0:0 rdy=1", hour, min, sec, set_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_day_wrap();
        test_set();
        test_back_to_back();
        test_alarm();
        test_alarm_guards();
        test_reset_in_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Time-of-day core of the wall clock. It consumes the 1 ms tick pulse from the millisecond tick generator and keeps milliseconds, seconds, minutes and hours. It accepts a validated set-time request over a valid/ready handshake and raises a latched alarm flag when the time reaches a programmed HH:MM:00. Its outputs feed the display formatter and the alarm driver.

## Interface

Parameters:
- MS_PER_SEC, default 1000: ms_tick pulses per second. Smaller values are for simulation only; must be ≥ 2.
- HOURS, default 24: hour modulus. Hour range is 0..HOURS-1; must be ≤ 32.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ms_tick  in  1  one-cycle pulse, once per millisecond, from the upstream tick generator.
- set_valid  in  1  set-time request.
- set_ready  out  1  high when a request can be accepted.
- set_hour  in  5  requested hour.
- set_min  in  6  requested minute.
- set_sec  in  6  requested second.
- set_err  out  1  one-cycle pulse: the request was rejected as out of range.
- alarm_en  in  1  alarm enable.
- alarm_hour  in  5  alarm hour.
- alarm_min  in  6  alarm minute.
- alarm_ack  in  1  clears alarm_flag.
- alarm_flag  out  1  latched alarm indication.
- ms  out  10  0..MS_PER_SEC-1.
- sec  out  6  0..59.
- min  out  6  0..59.
- hour  out  5  0..HOURS-1.
- sec_tick  out  1  one-cycle pulse on each second rollover.

## Operation

- Reset values: state RUN, ms=sec=min=hour=0, set_ready=1, set_err=0, alarm_flag=0, sec_tick=0.
- States:
  - RUN: counts ticks and accepts requests.
  - LOAD: one cycle; writes the captured request.
- Counting in RUN, per ms_tick:
  - If ms < MS_PER_SEC-1: ms+1.
  - Otherwise ms←0 and sec+1, with carry.
  - sec 59→0 carries into min; min 59→0 carries into hour; hour HOURS-1→0 wraps.
  - Plain modular arithmetic; no intermediate overflow.
- Set handshake:
  - A transfer occurs when set_valid && set_ready in RUN.
  - In range (hour<HOURS, min≤59, sec≤59): fields are captured, the block goes to LOAD and set_ready=0 for that cycle. In LOAD, hour/min/sec←captured values and ms←0, then back to RUN.
  - Out of range: time is unchanged, set_err pulses for one cycle and the block stays in RUN.
  - An ms_tick arriving in the transfer cycle or the LOAD cycle is discarded.
- Alarm:
  - Fires when alarm_en=1 and a counting rollover produces sec=0 with min=alarm_min and hour=alarm_hour.
  - A LOAD that sets an exactly matching time never fires.
  - alarm_flag stays set until alarm_ack=1 or alarm_en=0.
  - Fire and ack in the same cycle: fire wins, flag stays 1.
  - alarm_en=0 clears the flag and suppresses firing.
- alarm_hour/alarm_min are sampled live; changing them does not retroactively fire.
- Reset during LOAD discards the captured request; all outputs return to reset values.

## Timing

- Outputs are registered.
- ms_tick in cycle N: updated ms/sec/min/hour are visible in N+1.
- sec_tick and a newly fired alarm_flag assert in N+1, coincident with the new sec value.
- Set request accepted in cycle N: LOAD in N+1; loaded values and ms=0 visible in N+2; set_ready=1 again in N+2.
- Rejected request in cycle N: set_err=1 in N+1.
- Ticks every cycle are legal and each is counted, except those discarded by a set.
- set_valid held high after acceptance is treated as a new request once set_ready returns.
- alarm_ack or alarm_en=0 in cycle N: flag low in N+1.

## Test plan

- Reset then rollover (MS_PER_SEC=4): 4 ticks → ms 0,1,2,3,0; sec=1 and sec_tick=1 for exactly one cycle after the 4th tick.
- Full-day wrap (MS_PER_SEC=4): load 23:59:59, then 4 ticks → 00:00:00, ms=0, one sec_tick.
- Set handshake: request 12:34:56 with a coincident ms_tick → set_ready low one cycle; 12:34:56, ms=0 two cycles later; tick not counted. Request 24:00:00 → set_err pulse, time unchanged, set_ready stays 1.
- Alarm fire/ack (alarm 07:30): load 07:29:59, run to the rollover → alarm_flag=1 at 07:30:00. Hold; ack → flag 0. Assert ack on the fire cycle → flag stays 1.
- Alarm guards: load 07:30:00 directly → no fire. alarm_en=0 at the rollover → no fire. Deassert alarm_en while the flag is set → flag 0 next cycle.
- Reset in LOAD: assert reset in the LOAD cycle → time 00:00:00, state RUN, set_ready=1, no set_err.
